// File: rtl/sram_burst_tester.sv
// sram_burst_tester
// Autonomous burst exerciser for an external asynchronous SRAM. After a
// start request it performs BURST_LEN accesses from a latched base address,
// writing and/or reading an incrementing pattern derived from a latched seed,
// and reports the number of verify mismatches, the first failing address and
// the most recent word read back.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   start        single-cycle request, honoured only when idle
//   mode         0 write-only, 1 read-only, 2 write+verify, 3 write+verify inverted
//   baseAddr     first burst address (latched at start)
//   seed         pattern seed (latched at start)
//   dataBus      bidirectional SRAM data, driven only during write accesses
//   addrBus      SRAM address
//   memRead      SRAM output enable, active-low
//   memWrite     SRAM write enable, active-low
//   memEnable    SRAM chip enable, active-low
//   busy         burst in progress
//   done         one-cycle pulse at burst end
//   errCount     saturating verify mismatch count
//   firstErrAddr address of the first mismatch, 0 if none
//   lastRead     most recent word sampled from dataBus
module sram_burst_tester #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 18,
    parameter int BURST_LEN  = 16,
    parameter int ACCESS_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [DATA_W-1:0] seed,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic [ADDR_W-1:0] addrBus,
    output logic              memRead,
    output logic              memWrite,
    output logic              memEnable,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  errCount,
    output logic [ADDR_W-1:0] firstErrAddr,
    output logic [DATA_W-1:0] lastRead
);

    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CYC_W = $clog2(ACCESS_CYC);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(ACCESS_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] MODE_WO  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_WVI = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_TURN  = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Pattern word for burst index i; mode 3 uses the inverted word.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [DATA_W-1:0] s,
        input logic [IDX_W-1:0]  i,
        input logic [1:0]        m
    );
        logic [DATA_W-1:0] p;
        p = s + DATA_W'(i);
        if (m == MODE_WVI) begin
            pattern = ~p;
        end else begin
            pattern = p;
        end
    endfunction

    state_t            state_r,  state_s;
    logic [IDX_W-1:0]  idx_r,    idx_s;
    logic [CYC_W-1:0]  cyc_r,    cyc_s;
    logic [1:0]        mode_r,   mode_s;
    logic [ADDR_W-1:0] base_r,   base_s;
    logic [DATA_W-1:0] seed_r,   seed_s;
    logic              accept_s;

    logic [ADDR_W-1:0] addr_r,   addr_s;
    logic [DATA_W-1:0] wdata_r,  wdata_s;
    logic              drive_r,  drive_s;
    logic              mem_read_r,   mem_read_s;
    logic              mem_write_r,  mem_write_s;
    logic              mem_enable_r, mem_enable_s;
    logic              busy_r,   busy_s;
    logic              done_r,   done_s;

    logic [CNT_W-1:0]  err_cnt_r;
    logic [ADDR_W-1:0] first_err_r;
    logic              err_seen_r;
    logic [DATA_W-1:0] last_read_r;
    logic              sample_s;
    logic              mismatch_s;
    logic              in_write_s;
    logic              in_read_s;

    // Next-state logic: sequencing of accesses, index and per-access cycle counter.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        cyc_s    = cyc_r;
        mode_s   = mode_r;
        base_s   = base_r;
        seed_s   = seed_r;
        accept_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    mode_s   = mode;
                    base_s   = baseAddr;
                    seed_s   = seed;
                    idx_s    = IDX_ZERO;
                    cyc_s    = CYC_ZERO;
                    state_s  = (mode == MODE_RO) ? S_READ : S_WRITE;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_WRITE: begin
                if (cyc_r == CYC_LAST) begin
                    cyc_s = CYC_ZERO;
                    if (idx_r == IDX_LAST) begin
                        idx_s   = IDX_ZERO;
                        state_s = (mode_r == MODE_WO) ? S_DONE : S_TURN;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            S_TURN: begin
                // Bus turnaround: one idle cycle between the last write and first read.
                state_s = S_READ;
                idx_s   = IDX_ZERO;
                cyc_s   = CYC_ZERO;
            end
            S_READ: begin
                if (cyc_r == CYC_LAST) begin
                    cyc_s = CYC_ZERO;
                    if (idx_r == IDX_LAST) begin
                        idx_s   = IDX_ZERO;
                        state_s = S_DONE;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                idx_s   = IDX_ZERO;
                cyc_s   = CYC_ZERO;
            end
        endcase
    end

    // Output decode from the next state, so every bus pin comes straight from a flop.
    always_comb begin
        in_write_s   = (state_s == S_WRITE);
        in_read_s    = (state_s == S_READ);
        mem_enable_s = ~(in_write_s | in_read_s);
        mem_read_s   = ~in_read_s;
        // First cycle of each write is address/data setup with the strobe inactive.
        mem_write_s  = ~(in_write_s && (cyc_s != CYC_ZERO));
        drive_s      = in_write_s;
        busy_s       = in_write_s | in_read_s | (state_s == S_TURN);
        done_s       = (state_s == S_DONE);
        if (in_write_s || in_read_s) begin
            addr_s = base_s + ADDR_W'(idx_s);
        end else begin
            addr_s = addr_r;
        end
        if (in_write_s) begin
            wdata_s = pattern(seed_s, idx_s, mode_s);
        end else begin
            wdata_s = wdata_r;
        end
    end

    // Read sampling point and verify compare (modes 2 and 3 only).
    always_comb begin
        sample_s = (state_r == S_READ) && (cyc_r == CYC_LAST);
        if (sample_s && mode_r[1]) begin
            mismatch_s = (dataBus != pattern(seed_r, idx_r, mode_r));
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // State, sequencing and registered SRAM/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            idx_r        <= IDX_ZERO;
            cyc_r        <= CYC_ZERO;
            mode_r       <= 2'd0;
            base_r       <= {ADDR_W{1'b0}};
            seed_r       <= {DATA_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            drive_r      <= 1'b0;
            mem_read_r   <= 1'b1;
            mem_write_r  <= 1'b1;
            mem_enable_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cyc_r        <= cyc_s;
            mode_r       <= mode_s;
            base_r       <= base_s;
            seed_r       <= seed_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            drive_r      <= drive_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            mem_enable_r <= mem_enable_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    // Result registers: cleared on an accepted start, updated at each read sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r   <= {CNT_W{1'b0}};
            first_err_r <= {ADDR_W{1'b0}};
            err_seen_r  <= 1'b0;
            last_read_r <= {DATA_W{1'b0}};
        end else begin
            if (accept_s) begin
                err_cnt_r   <= {CNT_W{1'b0}};
                first_err_r <= {ADDR_W{1'b0}};
                err_seen_r  <= 1'b0;
            end else if (mismatch_s) begin
                if (err_cnt_r != CNT_MAX) begin
                    err_cnt_r <= err_cnt_r + CNT_ONE;
                end
                if (!err_seen_r) begin
                    // addr_r still holds the address of the access being sampled.
                    first_err_r <= addr_r;
                end
                err_seen_r <= 1'b1;
            end
            if (sample_s) begin
                last_read_r <= dataBus;
            end
        end
    end

    assign dataBus      = drive_r ? wdata_r : {DATA_W{1'bz}};
    assign addrBus      = addr_r;
    assign memRead      = mem_read_r;
    assign memWrite     = mem_write_r;
    assign memEnable    = mem_enable_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign errCount     = err_cnt_r;
    assign firstErrAddr = first_err_r;
    assign lastRead     = last_read_r;

endmodule
